// File: rtl/depuncturer_pkg.sv
// Shared WiFi demodulator definitions: code-rate encodings and depuncturing tables.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
package depuncturer_pkg;

  // Code rate as carried on the rate input
  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2,
    RATE_5_6 = 2'd3
  } rate_e;

  localparam int unsigned SOFT_W     = 3;
  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned PAIR_CNT_W = 16;

  // Number of received soft bits per puncturing period, indexed by rate
  localparam logic [PHASE_W-1:0] PERIOD_LEN [4] = '{3'd2, 3'd3, 3'd4, 3'd6};

  // Bit p set when received position p of the period is a B bit.
  //   1/2: A1 B1            2/3: A1 B1 A2
  //   3/4: A1 B1 A2 B3      5/6: A1 B1 A2 B3 A4 B5
  localparam logic [7:0] B_POS_MASK [4] = '{
    8'b0000_0010,
    8'b0000_0010,
    8'b0000_1010,
    8'b0010_1010
  };

  // Phase index of the last received position in the period
  function automatic logic [PHASE_W-1:0] period_last_phase(input logic [1:0] rate);
    return PERIOD_LEN[rate] - 3'd1;
  endfunction

endpackage

// File: rtl/depuncture_pattern.sv
// Maps (rate, phase) to the role of the received soft bit in the puncturing period.
// Latency: combinational, zero cycles.
// Backpressure: none; pure lookup.
module depuncture_pattern
  import depuncturer_pkg::*;
(
  input  logic [1:0]         rate_i,
  input  logic [PHASE_W-1:0] phase_i,
  output logic               is_b_o,
  output logic               emit_o,
  output logic               period_last_o
);

  // Table lookup; phase 0 is always A1, which is held rather than emitted
  always_comb begin
    is_b_o        = B_POS_MASK[rate_i][phase_i];
    emit_o        = (phase_i != '0);
    period_last_o = (phase_i == period_last_phase(rate_i));
  end

endmodule

// File: rtl/depuncturer.sv
// Rebuilds mother-code A/B soft-bit pairs from a punctured serial stream, inserting erasures.
// Latency: one cycle from the completing input to the registered output pair.
// Backpressure: none; at most one input per cycle yields at most one pair per cycle.
module depuncturer
  import depuncturer_pkg::*;
#(
  parameter int          Z         = 0,
  parameter logic [2:0]  ERASE_VAL = 3'h0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pkt_start_i,
  input  logic [1:0]            rate_i,
  input  logic [SOFT_W-1:0]     data_in_i,
  input  logic                  data_in_dv_i,
  output logic [SOFT_W-1:0]     data_a_o,
  output logic [SOFT_W-1:0]     data_b_o,
  output logic                  erase_a_o,
  output logic                  erase_b_o,
  output logic                  data_out_dv_o,
  output logic [PAIR_CNT_W-1:0] pair_cnt_o
);

  // Registers update with zero delay; a nonzero Z has no synthesizable meaning here
  if (Z != 0) begin : g_z_nonzero
    $error("depuncturer: only Z = 0 is supported");
  end

  logic [1:0]            rate_q, rate_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [SOFT_W-1:0]     held_a_q, held_a_d;
  logic [SOFT_W-1:0]     data_a_q, data_a_d;
  logic [SOFT_W-1:0]     data_b_q, data_b_d;
  logic                  erase_a_q, erase_a_d;
  logic                  erase_b_q, erase_b_d;
  logic                  out_dv_q, out_dv_d;
  logic [PAIR_CNT_W-1:0] pair_cnt_q, pair_cnt_d;

  // Packet-start view of the state: a start re-bases everything before the
  // coincident input (if any) is interpreted, so that input becomes phase 0
  logic [1:0]            rate_cur;
  logic [PHASE_W-1:0]    phase_cur;
  logic [SOFT_W-1:0]     held_a_cur;
  logic [PAIR_CNT_W-1:0] pair_cnt_cur;

  logic is_b, emit, period_last;

  // Select live state or freshly restarted packet state
  always_comb begin
    rate_cur     = rate_q;
    phase_cur    = phase_q;
    held_a_cur   = held_a_q;
    pair_cnt_cur = pair_cnt_q;
    if (pkt_start_i) begin
      rate_cur     = rate_i;
      phase_cur    = '0;
      held_a_cur   = '0;
      pair_cnt_cur = '0;
    end
  end

  depuncture_pattern u_pattern (
    .rate_i        (rate_cur),
    .phase_i       (phase_cur),
    .is_b_o        (is_b),
    .emit_o        (emit),
    .period_last_o (period_last)
  );

  // Next state: advance phase on valid input, hold A1 or build the output pair
  always_comb begin
    rate_d     = rate_cur;
    phase_d    = phase_cur;
    held_a_d   = held_a_cur;
    pair_cnt_d = pair_cnt_cur;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    erase_a_d  = erase_a_q;
    erase_b_d  = erase_b_q;
    out_dv_d   = 1'b0;
    if (data_in_dv_i) begin
      phase_d = period_last ? '0 : phase_cur + 3'd1;
      if (!emit) begin
        held_a_d = data_in_i;
      end else begin
        out_dv_d   = 1'b1;
        pair_cnt_d = pair_cnt_cur + 16'd1;
        if (phase_cur == 3'd1) begin
          // B1 completes the only unpunctured pair of the period
          data_a_d  = held_a_cur;
          data_b_d  = data_in_i;
          erase_a_d = 1'b0;
          erase_b_d = 1'b0;
        end else if (is_b) begin
          data_a_d  = ERASE_VAL;
          data_b_d  = data_in_i;
          erase_a_d = 1'b1;
          erase_b_d = 1'b0;
        end else begin
          data_a_d  = data_in_i;
          data_b_d  = ERASE_VAL;
          erase_a_d = 1'b0;
          erase_b_d = 1'b1;
        end
      end
    end
  end

  // State and output registers; reset aborts any packet in flight
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rate_q     <= RATE_1_2;
      phase_q    <= '0;
      held_a_q   <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      erase_a_q  <= 1'b0;
      erase_b_q  <= 1'b0;
      out_dv_q   <= 1'b0;
      pair_cnt_q <= '0;
    end else begin
      rate_q     <= rate_d;
      phase_q    <= phase_d;
      held_a_q   <= held_a_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
      erase_a_q  <= erase_a_d;
      erase_b_q  <= erase_b_d;
      out_dv_q   <= out_dv_d;
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign data_a_o      = data_a_q;
  assign data_b_o      = data_b_q;
  assign erase_a_o     = erase_a_q;
  assign erase_b_o     = erase_b_q;
  assign data_out_dv_o = out_dv_q;
  assign pair_cnt_o    = pair_cnt_q;

endmodule

// File: tb/tb_depuncturer.sv
// Scoreboard bench for the depuncturer: directed scenarios plus randomized traffic.
// Latency: expects each pair one cycle after its completing input.
// Backpressure: none to exercise; input gaps and restarts are randomized.
module tb_depuncturer;

  localparam logic [2:0] EV = 3'h5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pkt_start;
  logic [1:0]  rate;
  logic [2:0]  din;
  logic        din_dv;
  logic [2:0]  data_a, data_b;
  logic        erase_a, erase_b, out_dv;
  logic [15:0] pair_cnt;

  depuncturer #(.Z(0), .ERASE_VAL(EV)) dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .pkt_start_i   (pkt_start),
    .rate_i        (rate),
    .data_in_i     (din),
    .data_in_dv_i  (din_dv),
    .data_a_o      (data_a),
    .data_b_o      (data_b),
    .erase_a_o     (erase_a),
    .erase_b_o     (erase_b),
    .data_out_dv_o (out_dv),
    .pair_cnt_o    (pair_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  a;
    logic [2:0]  b;
    logic        ea;
    logic        eb;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: the received sequence of each rate written out as letters
  string pat [4] = '{"AB", "ABA", "ABAB", "ABABAB"};
  int          m_rate = 0;
  int          m_k    = 0;
  logic [2:0]  m_held = '0;
  logic [15:0] m_cnt  = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] a, input logic [2:0] b, input logic ea, input logic eb);
    exp_t e;
    m_cnt = m_cnt + 16'd1;
    e.a = a; e.b = b; e.ea = ea; e.eb = eb; e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic model_in(input bit start, input logic [1:0] r, input bit dv, input logic [2:0] d);
    string s;
    if (start) begin
      m_rate = int'(r);
      m_k    = 0;
      m_cnt  = '0;
    end
    if (dv) begin
      s = pat[m_rate];
      if (m_k == 0)        m_held = d;
      else if (m_k == 1)   push_exp(m_held, d, 1'b0, 1'b0);
      else if (s[m_k] == "A") push_exp(d, EV, 1'b0, 1'b1);
      else                 push_exp(EV, d, 1'b1, 1'b0);
      m_k = (m_k + 1) % s.len();
    end
  endtask

  // Called at posedge+1; leaves the bench at the next posedge+1 with inputs idle
  task automatic drive(input bit start, input logic [1:0] r, input bit dv, input logic [2:0] d);
    pkt_start = start;
    rate      = r;
    din       = d;
    din_dv    = dv;
    model_in(start, r, dv, d);
    @(posedge clk); #1;
    pkt_start = 1'b0;
    din_dv    = 1'b0;
    din       = 3'($urandom);
    rate      = 2'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_pulse();
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_data_a", 32'(data_a), 32'd0);
    check("rst_data_b", 32'(data_b), 32'd0);
    check("rst_erase_a", 32'(erase_a), 32'd0);
    check("rst_erase_b", 32'(erase_b), 32'd0);
    check("rst_out_dv", 32'(out_dv), 32'd0);
    check("rst_pair_cnt", 32'(pair_cnt), 32'd0);
    m_rate = 0;
    m_k    = 0;
    m_cnt  = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops an expected pair whenever the DUT presents one, else checks hold
  initial begin
    logic [2:0] la, lb;
    logic       lea, leb;
    exp_t       e;
    la = '0; lb = '0; lea = 1'b0; leb = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        la = '0; lb = '0; lea = 1'b0; leb = 1'b0;
      end else if (out_dv) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_pair: got (%0h,%0h) required none at %0t", data_a, data_b, $time);
        end else begin
          e = exp_q.pop_front();
          check("pair_a", 32'(data_a), 32'(e.a));
          check("pair_b", 32'(data_b), 32'(e.b));
          check("pair_erase_a", 32'(erase_a), 32'(e.ea));
          check("pair_erase_b", 32'(erase_b), 32'(e.eb));
          check("pair_cnt", 32'(pair_cnt), 32'(e.cnt));
        end
        la = data_a; lb = data_b; lea = erase_a; leb = erase_b;
      end else begin
        check("hold_a", 32'(data_a), 32'(la));
        check("hold_b", 32'(data_b), 32'(lb));
        check("hold_erase_a", 32'(erase_a), 32'(lea));
        check("hold_erase_b", 32'(erase_b), 32'(leb));
      end
    end
  end

  initial begin
    int roll;
    rst_n = 1'b0; pkt_start = 1'b0; rate = '0; din = '0; din_dv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("init_data_a", 32'(data_a), 32'd0);
    check("init_data_b", 32'(data_b), 32'd0);
    check("init_out_dv", 32'(out_dv), 32'd0);
    check("init_pair_cnt", 32'(pair_cnt), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // Before any packet start: rate 1/2 from phase 0
    drive(0, 2'd3, 1, 3'd2);
    drive(0, 2'd3, 1, 3'd4);
    idle(2);
    check("noinit_pair_cnt", 32'(pair_cnt), 32'd1);

    // Rate 1/2, inputs 1..4
    drive(1, 2'd0, 1, 3'd1);
    for (int i = 2; i <= 4; i++) drive(0, 2'd0, 1, 3'(i));
    idle(2);
    check("r12_pair_cnt", 32'(pair_cnt), 32'd2);

    // Rate 3/4, inputs 1..4
    drive(1, 2'd2, 1, 3'd1);
    for (int i = 2; i <= 4; i++) drive(0, 2'd0, 1, 3'(i));
    idle(2);
    check("r34_pair_cnt", 32'(pair_cnt), 32'd3);

    // Rate 5/6 with a 10-cycle gap after input 3
    drive(1, 2'd3, 1, 3'd1);
    drive(0, 2'd0, 1, 3'd2);
    drive(0, 2'd0, 1, 3'd3);
    idle(10);
    for (int i = 4; i <= 6; i++) drive(0, 2'd0, 1, 3'(i));
    idle(2);
    check("r56_pair_cnt", 32'(pair_cnt), 32'd5);

    // Rate 2/3, then restart at rate 1/2 coincident with an input
    drive(1, 2'd1, 1, 3'd1);
    drive(0, 2'd0, 1, 3'd2);
    drive(0, 2'd0, 1, 3'd3);
    drive(1, 2'd0, 1, 3'd7);
    drive(0, 2'd2, 1, 3'd1);
    idle(2);
    check("restart_pair_cnt", 32'(pair_cnt), 32'd1);

    // Restart while A1 is held discards it
    drive(1, 2'd0, 1, 3'd6);
    drive(1, 2'd0, 0, 3'd0);
    drive(0, 2'd0, 1, 3'd2);
    drive(0, 2'd0, 1, 3'd3);
    idle(2);
    check("discard_pair_cnt", 32'(pair_cnt), 32'd1);

    // Reset between A1 and B1
    drive(1, 2'd0, 1, 3'd3);
    reset_pulse();
    drive(0, 2'd0, 1, 3'd5);
    drive(0, 2'd0, 1, 3'd6);
    idle(2);
    check("post_rst_pair_cnt", 32'(pair_cnt), 32'd1);

    // Randomized traffic
    for (int it = 0; it < 1500; it++) begin
      roll = $urandom_range(0, 99);
      if (roll < 2)       reset_pulse();
      else if (roll < 8)  drive(1, 2'($urandom), 1'($urandom), 3'($urandom));
      else if (roll < 30) idle($urandom_range(1, 4));
      else                drive(0, 2'($urandom), 1, 3'($urandom));
    end
    idle(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("final_pair_cnt", 32'(pair_cnt), 32'(m_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
